// File: rtl/osd_rom_arb.sv
// osd_rom_arb: two-requester read arbiter in front of a synchronous ROM.
// Accepts at most one read per clock, tracks in-flight reads with an
// RD_LAT-deep tag pipeline and steers the shared read data to the owner.
// Build option: define OSD_ROM_ARB_RR_EN for round-robin contention
// resolution; left undefined, requester 0 has fixed priority.
module osd_rom_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_clk_en,
    output logic                  rom_rd_oce,
    output logic                  rom_rst,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  busy
);

    logic [1:0]            rst_sync_r;
    logic                  win0_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  accept_s;
    logic [ADDR_WIDTH-1:0] gnt_addr_s;
    logic [ADDR_WIDTH-1:0] addr_hold_r;
    logic [RD_LAT-1:0]     tag_vld_r;
    logic [RD_LAT-1:0]     tag_id_r;

`ifdef OSD_ROM_ARB_RR_EN
    logic                  last_grant_r;

    // Round-robin: whichever requester was not granted last wins a tie.
    assign win0_s = last_grant_r;

    // Remember the most recent winner; reset to 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= gnt1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: requester 0 always wins a tie.
    assign win0_s = 1'b1;
`endif

    // Two-flop synchronizer on reset release; grants stay off until it is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Grant decision; depends only on valids and arbitration state.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_sync_r[1]) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0_valid && (!req1_valid || win0_s)) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign accept_s   = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Address mux: granted address in an accept cycle, otherwise the held one.
    always_comb begin
        gnt_addr_s = addr_hold_r;
        if (gnt0_s) begin
            gnt_addr_s = req0_addr;
        end else if (gnt1_s) begin
            gnt_addr_s = req1_addr;
        end else begin
            gnt_addr_s = addr_hold_r;
        end
    end

    // Hold the last granted address so the ROM address is stable when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_r <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            addr_hold_r <= gnt_addr_s;
        end else begin
            addr_hold_r <= addr_hold_r;
        end
    end

    // Tag pipeline: stage 0 captures the accept, last stage marks the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= {RD_LAT{1'b0}};
            tag_id_r  <= {RD_LAT{1'b0}};
        end else begin
            tag_vld_r[0] <= accept_s;
            tag_id_r[0]  <= gnt1_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    assign rsp0_valid = tag_vld_r[RD_LAT-1] & ~tag_id_r[RD_LAT-1];
    assign rsp1_valid = tag_vld_r[RD_LAT-1] &  tag_id_r[RD_LAT-1];
    assign rsp_data   = rom_rd_data;
    assign rom_addr   = gnt_addr_s;
    assign busy       = |tag_vld_r;
    assign rom_clk_en = accept_s | busy;
    assign rom_rd_oce = (RD_LAT == 2) ? 1'b1 : 1'b0;
    assign rom_rst    = ~rst_n;

endmodule

// File: tb/tb_osd_rom_arb.sv
// Bench for osd_rom_arb: one instance with RD_LAT=1 and one with RD_LAT=2,
// each backed by a behavioural ROM. Expected responses go to a scoreboard
// queue when a grant is predicted and are checked when responses appear.
module tb_osd_rom_arb;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef OSD_ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic          inst;
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    logic                 clk = 1'b0;
    logic [1:0]           rstn = 2'b11;
    logic [1:0]           v0, v1, r0, r1, rv0, rv1, ce, oce, rrst, busy;
    logic [1:0][AW-1:0]   a0, a1, ra;
    logic [1:0][DW-1:0]   rdat, rd;
    logic [DW-1:0]        st1;
    int                   cyc = 0;
    int                   n_cmp = 0;
    int                   n_err = 0;
    sb_t                  sbq[$];
    logic [1:0]           lg, en;
    logic [1:0][AW-1:0]   hold;
    int                   la[2];
    logic [AW-1:0]        pa0, pa1;
    sb_t                  m_e;
    logic [1:0]           m_exp;
    int                   m_k;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    osd_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rstn[0]),
        .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_ready(r1[0]),
        .rsp0_valid(rv0[0]), .rsp1_valid(rv1[0]), .rsp_data(rdat[0]),
        .rom_addr(ra[0]), .rom_clk_en(ce[0]), .rom_rd_oce(oce[0]),
        .rom_rst(rrst[0]), .rom_rd_data(rd[0]), .busy(busy[0])
    );

    osd_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rstn[1]),
        .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_ready(r1[1]),
        .rsp0_valid(rv0[1]), .rsp1_valid(rv1[1]), .rsp_data(rdat[1]),
        .rom_addr(ra[1]), .rom_clk_en(ce[1]), .rom_rd_oce(oce[1]),
        .rom_rst(rrst[1]), .rom_rd_data(rd[1]), .busy(busy[1])
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        logic [DW-1:0] x;
        x = {22'd0, a};
        return (x * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic string tg(input int i, input string s);
        return $sformatf("lat%0d_%s", i + 1, s);
    endfunction

    // Behavioural ROMs: latency 1 and latency 2 (with output register).
    always @(posedge clk) begin
        if (ce[0]) rd[0] <= rom_f(ra[0]);
        if (ce[1]) begin
            st1 <= rom_f(ra[1]);
            if (oce[1]) rd[1] <= st1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        lg[i]   = 1'b1;
        en[i]   = 1'b0;
        hold[i] = '0;
        la[i]   = -100;
        for (int k = sbq.size() - 1; k >= 0; k--)
            if (int'(sbq[k].inst) == i) sbq.delete(k);
    endtask

    // One clock of stimulus on instance i; called at a falling edge.
    task automatic step(input int i, input logic p0, input logic [AW-1:0] pa,
                        input logic p1, input logic [AW-1:0] pb);
        logic g0, g1, w0, bz;
        logic [AW-1:0] ga;
        sb_t e;
        v0[i] = p0; a0[i] = pa; v1[i] = p1; a1[i] = pb;
        w0 = RR ? lg[i] : 1'b1;
        g0 = en[i] && p0 && (!p1 || w0);
        g1 = en[i] && p1 && !g0;
        ga = g0 ? pa : (g1 ? pb : hold[i]);
        bz = ((cyc - la[i]) >= 1) && ((cyc - la[i]) <= i + 1);
        #1;
        chk(tg(i, "req0_ready"), r0[i], g0);
        chk(tg(i, "req1_ready"), r1[i], g1);
        chk(tg(i, "rom_addr"), ra[i], ga);
        chk(tg(i, "busy"), busy[i], bz);
        chk(tg(i, "rom_clk_en"), ce[i], g0 | g1 | bz);
        if (g0 || g1) begin
            e.inst = i[0]; e.id = g1; e.data = rom_f(ga); e.due = cyc + i + 1;
            sbq.push_back(e);
            hold[i] = ga; lg[i] = g1; la[i] = cyc;
        end
        @(negedge clk);
    endtask

    // Response monitor: pop the oldest expectation of each instance when due.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_exp = 2'b00;
            m_k   = -1;
            for (int k = 0; k < sbq.size(); k++)
                if (m_k < 0 && int'(sbq[k].inst) == i) m_k = k;
            if (m_k >= 0 && sbq[m_k].due == cyc) begin
                m_e = sbq[m_k];
                sbq.delete(m_k);
                m_exp = m_e.id ? 2'b10 : 2'b01;
            end
            chk(tg(i, "rsp_valid"), {rv1[i], rv0[i]}, m_exp);
            if (m_exp != 2'b00) chk(tg(i, "rsp_data"), rdat[i], m_e.data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        v0 = '0; v1 = '0; a0 = '0; a1 = '0;
        model_reset(0);
        model_reset(1);
        #2 rstn = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(tg(i, "rom_rst_in_reset"), rrst[i], 1'b1);
            chk(tg(i, "rom_rd_oce"), oce[i], (i == 1));
        end
        step(0, 1'b1, 10'h005, 1'b0, 10'h000);
        step(0, 1'b0, 10'h000, 1'b0, 10'h000);
        rstn = 2'b11;
        step(0, 1'b0, 10'h000, 1'b0, 10'h000);
        step(0, 1'b0, 10'h000, 1'b0, 10'h000);
        for (int i = 0; i < 2; i++) chk(tg(i, "rom_rst_run"), rrst[i], 1'b0);
        en = 2'b11;

        // Contention on the RD_LAT=2 instance (first contention after reset).
        pa0 = 10'h010;
        pa1 = 10'h020;
        for (int k = 0; k < 4; k++) begin
            step(1, RR || (k < 3), pa0, 1'b1, pa1);
            if (lg[1]) pa1 = pa1 + 10'd1;
            else       pa0 = pa0 + 10'd1;
        end
        for (int k = 0; k < 3; k++) step(1, 1'b0, 10'h000, 1'b0, 10'h000);

        // Single read of 0x005 on the RD_LAT=1 instance.
        step(0, 1'b1, 10'h005, 1'b0, 10'h000);
        for (int k = 0; k < 2; k++) step(0, 1'b0, 10'h000, 1'b0, 10'h000);

        // Requester 1 reads the last ROM word on the RD_LAT=2 instance.
        step(1, 1'b0, 10'h000, 1'b1, 10'h3FF);
        for (int k = 0; k < 3; k++) step(1, 1'b0, 10'h000, 1'b0, 10'h000);

        // Read of 0x0A0 then idle: address held, clock enable drops.
        step(0, 1'b1, 10'h0A0, 1'b0, 10'h000);
        for (int k = 0; k < 6; k++) step(0, 1'b0, 10'h000, 1'b0, 10'h000);
        chk("lat1_idle_rom_addr", ra[0], 10'h0A0);
        chk("lat1_idle_clk_en", ce[0], 1'b0);

        // Reset pulse with a read still in flight on the RD_LAT=2 instance.
        step(1, 1'b1, 10'h100, 1'b0, 10'h000);
        step(1, 1'b0, 10'h000, 1'b1, 10'h101);
        #2;
        rstn[1] = 1'b0;
        v0[1] = 1'b0;
        v1[1] = 1'b0;
        model_reset(1);
        #1;
        chk("lat2_rst_rom_rst", rrst[1], 1'b1);
        chk("lat2_rst_busy", busy[1], 1'b0);
        chk("lat2_rst_rsp", {rv1[1], rv0[1]}, 2'b00);
        @(negedge clk);
        step(1, 1'b1, 10'h123, 1'b0, 10'h000);
        rstn[1] = 1'b1;
        step(1, 1'b1, 10'h123, 1'b0, 10'h000);
        step(1, 1'b1, 10'h123, 1'b0, 10'h000);
        en[1] = 1'b1;
        step(1, 1'b1, 10'h123, 1'b0, 10'h000);
        for (int k = 0; k < 3; k++) step(1, 1'b0, 10'h000, 1'b0, 10'h000);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
